// File: rtl/rf_dump_reader_pkg.sv
// rtl/rf_dump_reader_pkg.sv - shared register-file widths and dump-walker state encoding
package rf_dump_reader_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } rf_dump_state_e;

endpackage

// File: rtl/rf_dump_reader.sv
// rtl/rf_dump_reader.sv - walks the register file one address at a time and streams each word out
// RF_DUMP_CHECKSUM_EN adds checksum_o, the XOR of every accepted word of the current dump.
module rf_dump_reader
  import rf_dump_reader_pkg::*;
#(
  parameter int ADDR_W    = RF_ADDR_W,
  parameter int DATA_W    = RF_DATA_W,
  parameter int SKIP_ZERO = 1
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic              start_i,
  input  logic              abort_i,
  output logic [ADDR_W-1:0] rf_addr_o,
  input  logic [DATA_W-1:0] rf_rd_i,
  output logic              dout_valid_o,
  input  logic              dout_ready_i,
  output logic [ADDR_W-1:0] dout_addr_o,
  output logic [DATA_W-1:0] dout_data_o,
  output logic              busy_o,
`ifdef RF_DUMP_CHECKSUM_EN
  output logic              done_o,
  output logic [DATA_W-1:0] checksum_o
`else
  output logic              done_o
`endif
);

  // x0 is hard-wired zero, so by default the walk skips it.
  localparam logic [ADDR_W-1:0] START_ADDR = (SKIP_ZERO != 0) ? ADDR_W'(1) : '0;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;

  rf_dump_state_e    state;
  rf_dump_state_e    state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic              start_acc;
  logic              capture;
  logic              handshake;

  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Abort wins over a handshake presented in the same cycle.
  always_comb begin
    state_nxt    = state;
    start_acc    = 1'b0;
    capture      = 1'b0;
    handshake    = 1'b0;
    rf_addr_o    = '0;
    dout_valid_o = 1'b0;
    busy_o       = 1'b1;
    done_o       = 1'b0;
    case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          start_acc = 1'b1;
          state_nxt = READ;
        end
      end
      READ: begin
        rf_addr_o = ptr;
        if (abort_i) begin
          state_nxt = IDLE;
        end else begin
          capture   = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        dout_valid_o = 1'b1;
        if (abort_i) begin
          state_nxt = IDLE;
        end else if (dout_ready_i) begin
          handshake = 1'b1;
          state_nxt = (ptr == LAST_ADDR) ? DONE : READ;
        end
      end
      DONE: begin
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ptr parks at the last address rather than wrapping back to zero.
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (start_acc) begin
      ptr <= START_ADDR;
    end else if (handshake && (ptr != LAST_ADDR)) begin
      ptr <= ptr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      dout_addr_o <= '0;
      dout_data_o <= '0;
    end else if (capture) begin
      dout_addr_o <= ptr;
      dout_data_o <= rf_rd_i;
    end
  end

`ifdef RF_DUMP_CHECKSUM_EN
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      checksum_o <= '0;
    end else if (start_acc) begin
      checksum_o <= '0;
    end else if (handshake) begin
      checksum_o <= checksum_o ^ dout_data_o;
    end
  end
`endif

endmodule

// File: tb/tb_rf_dump_reader.sv
// tb/tb_rf_dump_reader.sv - scoreboard bench for rf_dump_reader (SKIP_ZERO=1 and SKIP_ZERO=0 instances)
// Checksum checks are compiled in when RF_DUMP_CHECKSUM_EN is defined.
module tb_rf_dump_reader;

  localparam int AW = 5;
  localparam int DW = 32;

  typedef struct {
    int          addr;
    logic [DW-1:0] data;
    int          cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start_a = 1'b0, abort_a = 1'b0, ready_a = 1'b0;
  logic          start_b = 1'b0, abort_b = 1'b0, ready_b = 1'b0;
  logic [AW-1:0] rf_addr_a, rf_addr_b, addr_a, addr_b;
  logic [DW-1:0] rd_a, rd_b, data_a, data_b;
  logic          valid_a, valid_b, busy_a, busy_b, done_a, done_b;
`ifdef RF_DUMP_CHECKSUM_EN
  logic [DW-1:0] csum_a, csum_b;
`endif

  logic [DW-1:0] mem [32];
  exp_t          qa[$];
  exp_t          qb[$];
  logic [DW-1:0] exp_sum_a, exp_sum_b;
  int            n_chk = 0, n_pass = 0, cyc = 0;
  int            done_cnt_a = 0, done_cnt_b = 0, words_b = 0;
  bit            follow_a = 1'b0, follow_b = 1'b0;

  assign rd_a = mem[rf_addr_a];
  assign rd_b = mem[rf_addr_b];

  rf_dump_reader #(.ADDR_W(AW), .DATA_W(DW), .SKIP_ZERO(1)) dut_a (
    .clk_i        (clk),
    .reset        (reset),
    .start_i      (start_a),
    .abort_i      (abort_a),
    .rf_addr_o    (rf_addr_a),
    .rf_rd_i      (rd_a),
    .dout_valid_o (valid_a),
    .dout_ready_i (ready_a),
    .dout_addr_o  (addr_a),
    .dout_data_o  (data_a),
    .busy_o       (busy_a),
`ifdef RF_DUMP_CHECKSUM_EN
    .done_o       (done_a),
    .checksum_o   (csum_a)
`else
    .done_o       (done_a)
`endif
  );

  rf_dump_reader #(.ADDR_W(AW), .DATA_W(DW), .SKIP_ZERO(0)) dut_b (
    .clk_i        (clk),
    .reset        (reset),
    .start_i      (start_b),
    .abort_i      (abort_b),
    .rf_addr_o    (rf_addr_b),
    .rf_rd_i      (rd_b),
    .dout_valid_o (valid_b),
    .dout_ready_i (ready_b),
    .dout_addr_o  (addr_b),
    .dout_data_o  (data_b),
    .busy_o       (busy_b),
`ifdef RF_DUMP_CHECKSUM_EN
    .done_o       (done_b),
    .checksum_o   (csum_b)
`else
    .done_o       (done_b)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_rf_addr"}, rf_addr_a, 0);
    check({tag, "_a_dout_addr"}, addr_a, 0);
    check({tag, "_a_dout_data"}, data_a, 0);
    check({tag, "_a_valid"}, valid_a, 0);
    check({tag, "_a_busy"}, busy_a, 0);
    check({tag, "_a_done"}, done_a, 0);
    check({tag, "_b_rf_addr"}, rf_addr_b, 0);
    check({tag, "_b_dout_data"}, data_b, 0);
    check({tag, "_b_busy"}, busy_b, 0);
`ifdef RF_DUMP_CHECKSUM_EN
    check({tag, "_a_checksum"}, csum_a, 0);
`endif
  endtask

  task automatic rand_mem();
    mem[0] = '0;
    for (int i = 1; i < 32; i++) mem[i] = $urandom;
  endtask

  // Expected dump: every address from the start address up to 31, in order.
  task automatic issue_start_a(input bit timed);
    int s;
    @(posedge clk); #1;
    start_a = 1'b1;
    ready_a = 1'b1;
    s = cyc + 1;
    exp_sum_a = '0;
    for (int a = 1; a < 32; a++) begin
      qa.push_back('{a, mem[a], timed ? s + 2 + 2 * (a - 1) : -1});
      exp_sum_a ^= mem[a];
    end
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic issue_start_b();
    @(posedge clk); #1;
    start_b = 1'b1;
    exp_sum_b = '0;
    for (int a = 0; a < 32; a++) begin
      qb.push_back('{a, mem[a], -1});
      exp_sum_b ^= mem[a];
    end
    @(posedge clk); #1;
    start_b = 1'b0;
  endtask

  // mode 0: ready always high; 1: random ready, 5-cycle stall on addr 4, stray start at addr 15;
  // mode 2: abort while presenting addr 7; mode 3: reset while presenting addr 10.
  task automatic drive_a(input int mode, input int budget);
    int n = 0;
    int stall = 0;
    int d0 = done_cnt_a;
    bit stop = 1'b0;
    while (!stop && n < budget) begin
      @(posedge clk); #1;
      n++;
      start_a = 1'b0;
      if (done_cnt_a != d0) begin
        stop = 1'b1;
      end else begin
        case (mode)
          0: ready_a = 1'b1;
          1: begin
            start_a = valid_a && (addr_a == 15);
            if (valid_a && addr_a == 4) begin
              ready_a = (stall >= 5);
              if (stall < 5) stall++;
            end else begin
              ready_a = 1'($urandom_range(0, 1));
            end
          end
          2: begin
            if (valid_a && addr_a == 7) begin
              ready_a = 1'b1;
              abort_a = 1'b1;
              @(posedge clk); #1;
              abort_a = 1'b0;
              check("abort_busy_next", busy_a, 0);
              check("abort_valid_next", valid_a, 0);
              qa.delete();
              stop = 1'b1;
            end else begin
              ready_a = 1'($urandom_range(0, 1));
            end
          end
          default: begin
            if (valid_a && addr_a == 10) begin
              #2;
              reset = 1'b0;
              #1;
              check_all_zero("midreset");
              qa.delete();
              repeat (2) @(posedge clk);
              #1;
              reset = 1'b1;
              stop = 1'b1;
            end else begin
              ready_a = 1'($urandom_range(0, 1));
            end
          end
        endcase
      end
    end
    start_a = 1'b0;
    check("a_drive_finished", stop, 1);
  endtask

  // Monitor: pops the scoreboard on every accepted word and audits done/busy behaviour.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid_a && ready_a && !abort_a) begin
        if (qa.size() == 0) check("a_spurious_word", 1, 0);
        else begin
          e = qa.pop_front();
          check("a_addr", addr_a, e.addr);
          check("a_data", data_a, e.data);
          if (e.cyc >= 0) check("a_hs_cycle", cyc + 1, e.cyc);
        end
      end else if (valid_a && !ready_a && qa.size() > 0) begin
        check("a_stall_addr", addr_a, qa[0].addr);
        check("a_stall_data", data_a, qa[0].data);
      end
      if (follow_a) begin
        check("a_done_one_cycle", done_a, 0);
        check("a_busy_after_done", busy_a, 0);
      end
      follow_a = done_a;
      if (done_a) begin
        done_cnt_a++;
        check("a_done_all_words", qa.size(), 0);
        check("a_rf_addr_done", rf_addr_a, 0);
`ifdef RF_DUMP_CHECKSUM_EN
        check("a_checksum", csum_a, exp_sum_a);
`endif
      end

      if (valid_b && ready_b && !abort_b) begin
        if (qb.size() == 0) check("b_spurious_word", 1, 0);
        else begin
          e = qb.pop_front();
          words_b++;
          check("b_addr", addr_b, e.addr);
          check("b_data", data_b, e.data);
        end
      end
      if (follow_b) check("b_done_one_cycle", done_b, 0);
      follow_b = done_b;
      if (done_b) begin
        done_cnt_b++;
        check("b_done_all_words", qb.size(), 0);
`ifdef RF_DUMP_CHECKSUM_EN
        check("b_checksum", csum_b, exp_sum_b);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d0;
    mem[0] = '0;
    for (int i = 1; i < 32; i++) mem[i] = DW'(100 + i);
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    @(posedge clk); #1;
    check("idle_rf_addr", rf_addr_a, 0);

    // Full dump, data 101..131, fixed two-cycle cadence.
    issue_start_a(1'b1);
    drive_a(0, 200);
    check("full_dump_done_count", done_cnt_a, 1);

    rand_mem();
    issue_start_a(1'b0);
    drive_a(1, 2000);
    check("backpressure_done_count", done_cnt_a, 2);

    rand_mem();
    issue_start_a(1'b0);
    drive_a(2, 2000);
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt_a, 2);
    check("abort_stays_idle", busy_a, 0);
    issue_start_a(1'b0);
    drive_a(1, 2000);
    check("restart_done_count", done_cnt_a, 3);

    rand_mem();
    issue_start_a(1'b0);
    drive_a(3, 2000);
    ready_a = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("post_reset_idle", busy_a, 0);
    check("post_reset_no_done", done_cnt_a, 3);

    // SKIP_ZERO=0: addresses 0..31 including x0.
    rand_mem();
    issue_start_b();
    n = 0;
    d0 = done_cnt_b;
    while (done_cnt_b == d0 && n < 2000) begin
      @(posedge clk); #1;
      ready_b = 1'($urandom_range(0, 1));
      n++;
    end
    check("b_done_seen", done_cnt_b - d0, 1);
    check("b_word_count", words_b, 32);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
